// File: rtl/m_dram_arbiter_pkg.sv
// Shared state encoding, widths and owner-selection helper for the two-hart DRAM arbiter.
package m_dram_arbiter_pkg;

    localparam int ARB_NHARTS = 2;
    localparam int ARB_CTRL_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_ARM   = 2'd2,
        ARB_WAIT  = 2'd3
    } arb_state_t;

    // Owner for a pending mask; 'prefer' is the hart that takes a tie.
    function automatic logic pick_owner(input logic [1:0] pend, input logic prefer);
        if (pend[0] && pend[1]) begin
            return prefer;
        end
        return ~pend[0];
    endfunction

endpackage

// File: rtl/m_dram_arbiter_req_slot.sv
// Per-hart request slot: captures one request, holds pend/busy and the last load data.
// With SIM_MODE defined, a request pulse while already pending raises an assertion.
module m_dram_req_slot
    import m_dram_arbiter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  le,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [ARB_CTRL_W-1:0] ctrl,
    input  logic                  clear,
    input  logic [31:0]           dram_odata,
    output logic                  pend,
    output logic [31:0]           addr_q,
    output logic [31:0]           wdata_q,
    output logic [ARB_CTRL_W-1:0] ctrl_q,
    output logic                  write_q,
    output logic [31:0]           odata
);

    logic                  pend_reg;
    logic                  write_reg;
    logic [31:0]           addr_reg;
    logic [31:0]           wdata_reg;
    logic [ARB_CTRL_W-1:0] ctrl_reg;
    logic [31:0]           odata_reg;

    // clear only arrives while pending and capture only while idle, so they never collide
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_reg  <= 1'b0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ctrl_reg  <= '0;
            odata_reg <= '0;
        end else begin
            if ((le || we) && !pend_reg) begin
                pend_reg  <= 1'b1;
                write_reg <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                ctrl_reg  <= ctrl;
            end
            if (clear) begin
                pend_reg <= 1'b0;
                if (!write_reg) begin
                    odata_reg <= dram_odata;
                end
            end
        end
    end

`ifdef SIM_MODE
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(pend_reg && (le || we)))
                else $error("request pulse dropped: slot already pending");
        end
    end
`endif

    assign pend    = pend_reg;
    assign addr_q  = addr_reg;
    assign wdata_q = wdata_reg;
    assign ctrl_q  = ctrl_reg;
    assign write_q = write_reg;
    assign odata   = odata_reg;

endmodule

// File: rtl/m_dram_arbiter.sv
// Two-hart DRAM arbiter: one slot per hart, IDLE/ISSUE/ARM/WAIT grant FSM.
// DRAM_ARB_RR_EN selects round-robin tie-break; otherwise hart 0 has fixed priority.
module m_dram_arbiter
    import m_dram_arbiter_pkg::*;
#(
    parameter int NHARTS = ARB_NHARTS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           w_h0_addr,
    input  logic [31:0]           w_h0_wdata,
    input  logic [ARB_CTRL_W-1:0] w_h0_ctrl,
    input  logic                  w_h0_we,
    input  logic                  w_h0_le,
    output logic                  w_h0_busy,
    output logic [31:0]           w_h0_odata,
    input  logic [31:0]           w_h1_addr,
    input  logic [31:0]           w_h1_wdata,
    input  logic [ARB_CTRL_W-1:0] w_h1_ctrl,
    input  logic                  w_h1_we,
    input  logic                  w_h1_le,
    output logic                  w_h1_busy,
    output logic [31:0]           w_h1_odata,
    output logic [31:0]           w_grant,
    output logic [31:0]           w_dram_addr,
    output logic [31:0]           w_dram_wdata,
    output logic [ARB_CTRL_W-1:0] w_dram_ctrl,
    output logic                  w_dram_we_t,
    output logic                  w_dram_le,
    input  logic [31:0]           w_dram_odata,
    input  logic                  w_dram_busy
);

    logic [NHARTS-1:0]     hart_le;
    logic [NHARTS-1:0]     hart_we;
    logic [31:0]           hart_addr  [NHARTS];
    logic [31:0]           hart_wdata [NHARTS];
    logic [ARB_CTRL_W-1:0] hart_ctrl  [NHARTS];

    logic [NHARTS-1:0]     slot_pend;
    logic [NHARTS-1:0]     slot_write;
    logic [NHARTS-1:0]     slot_clear;
    logic [31:0]           slot_addr  [NHARTS];
    logic [31:0]           slot_wdata [NHARTS];
    logic [ARB_CTRL_W-1:0] slot_ctrl  [NHARTS];
    logic [31:0]           slot_odata [NHARTS];

    arb_state_t            state_reg;
    logic                  owner_reg;
    logic [31:0]           dram_addr_reg;
    logic [31:0]           dram_wdata_reg;
    logic [ARB_CTRL_W-1:0] dram_ctrl_reg;
    logic                  dram_we_reg;
    logic                  dram_le_reg;
    logic                  owner_next;
    logic                  wait_done;

    assign hart_le       = {w_h1_le, w_h0_le};
    assign hart_we       = {w_h1_we, w_h0_we};
    assign hart_addr[0]  = w_h0_addr;
    assign hart_addr[1]  = w_h1_addr;
    assign hart_wdata[0] = w_h0_wdata;
    assign hart_wdata[1] = w_h1_wdata;
    assign hart_ctrl[0]  = w_h0_ctrl;
    assign hart_ctrl[1]  = w_h1_ctrl;

    assign wait_done = (state_reg == ARB_WAIT) && !w_dram_busy;

    generate
        for (genvar gi = 0; gi < NHARTS; gi++) begin : g_slot
            assign slot_clear[gi] = wait_done && (owner_reg == 1'(gi));

            m_dram_req_slot u_slot (
                .CLK        (CLK),
                .RST        (RST),
                .le         (hart_le[gi]),
                .we         (hart_we[gi]),
                .addr       (hart_addr[gi]),
                .wdata      (hart_wdata[gi]),
                .ctrl       (hart_ctrl[gi]),
                .clear      (slot_clear[gi]),
                .dram_odata (w_dram_odata),
                .pend       (slot_pend[gi]),
                .addr_q     (slot_addr[gi]),
                .wdata_q    (slot_wdata[gi]),
                .ctrl_q     (slot_ctrl[gi]),
                .write_q    (slot_write[gi]),
                .odata      (slot_odata[gi])
            );
        end
    endgenerate

`ifdef DRAM_ARB_RR_EN
    logic last_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_reg <= 1'b1;
        end else if (state_reg == ARB_IDLE && |slot_pend) begin
            last_reg <= owner_next;
        end
    end

    assign owner_next = pick_owner(slot_pend, ~last_reg);
`else
    assign owner_next = pick_owner(slot_pend, 1'b0);
`endif

    // DRAM-side outputs are registered at the grant so they are valid for the whole ISSUE cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= 1'b0;
            dram_addr_reg  <= '0;
            dram_wdata_reg <= '0;
            dram_ctrl_reg  <= '0;
            dram_we_reg    <= 1'b0;
            dram_le_reg    <= 1'b0;
        end else begin
            dram_we_reg <= 1'b0;
            dram_le_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (|slot_pend) begin
                        owner_reg      <= owner_next;
                        dram_addr_reg  <= slot_addr[owner_next];
                        dram_wdata_reg <= slot_wdata[owner_next];
                        dram_ctrl_reg  <= slot_ctrl[owner_next];
                        dram_we_reg    <= slot_write[owner_next];
                        dram_le_reg    <= ~slot_write[owner_next];
                        state_reg      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: state_reg <= ARB_ARM;
                ARB_ARM:   state_reg <= ARB_WAIT;
                ARB_WAIT: begin
                    if (!w_dram_busy) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign w_h0_busy    = slot_pend[0];
    assign w_h1_busy    = slot_pend[1];
    assign w_h0_odata   = slot_odata[0];
    assign w_h1_odata   = slot_odata[1];
    assign w_grant      = {31'b0, owner_reg};
    assign w_dram_addr  = dram_addr_reg;
    assign w_dram_wdata = dram_wdata_reg;
    assign w_dram_ctrl  = dram_ctrl_reg;
    assign w_dram_we_t  = dram_we_reg;
    assign w_dram_le    = dram_le_reg;

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Bench for m_dram_arbiter: vector table plus hand-written tie/overlap/repeat/reset sequences,
// with a DRAM model that checks each issued pulse against a queue of expected requests.
module tb_m_dram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] w_h0_addr = '0, w_h0_wdata = '0, w_h1_addr = '0, w_h1_wdata = '0;
    logic [2:0]  w_h0_ctrl = '0, w_h1_ctrl = '0;
    logic        w_h0_we = 1'b0, w_h0_le = 1'b0, w_h1_we = 1'b0, w_h1_le = 1'b0;
    logic        w_h0_busy, w_h1_busy;
    logic [31:0] w_h0_odata, w_h1_odata, w_grant;
    logic [31:0] w_dram_addr, w_dram_wdata;
    logic [2:0]  w_dram_ctrl;
    logic        w_dram_we_t, w_dram_le;
    logic [31:0] w_dram_odata = '0;
    logic        w_dram_busy = 1'b0;

    always #5 CLK = ~CLK;

    m_dram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .w_h0_addr(w_h0_addr), .w_h0_wdata(w_h0_wdata), .w_h0_ctrl(w_h0_ctrl),
        .w_h0_we(w_h0_we), .w_h0_le(w_h0_le), .w_h0_busy(w_h0_busy), .w_h0_odata(w_h0_odata),
        .w_h1_addr(w_h1_addr), .w_h1_wdata(w_h1_wdata), .w_h1_ctrl(w_h1_ctrl),
        .w_h1_we(w_h1_we), .w_h1_le(w_h1_le), .w_h1_busy(w_h1_busy), .w_h1_odata(w_h1_odata),
        .w_grant(w_grant), .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
        .w_dram_ctrl(w_dram_ctrl), .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le),
        .w_dram_odata(w_dram_odata), .w_dram_busy(w_dram_busy)
    );

    typedef struct {
        logic [31:0] grant;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
    } issue_t;

    typedef struct {
        int          hart;
        logic        le;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
    } vec_t;

    issue_t      exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          busy_len = 0;
    int          busy_cnt = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc [2];
    logic [31:0] exp_odata [2];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // DRAM model: verifies each pulse against the scoreboard, then holds busy for busy_len cycles
    always @(negedge CLK) begin
        if (RST) begin
            busy_cnt    = 0;
            w_dram_busy = 1'b0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) w_dram_busy = 1'b0;
            end
            if (w_dram_le || w_dram_we_t) begin : mon_issue
                issue_t e;
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_pulse: got addr 0x%08h expected no pulse", w_dram_addr);
                end else begin
                    e = exp_q.pop_front();
                    pulse_cyc[w_grant[0]] = cyc;
                    $display("issue cyc=%0d hart=%0d we=%0d addr=0x%08h wdata=0x%08h ctrl=%0d",
                             cyc, w_grant, w_dram_we_t, w_dram_addr, w_dram_wdata, w_dram_ctrl);
                    chk("issue_grant", w_grant, e.grant);
                    chk("issue_we", {31'b0, w_dram_we_t}, {31'b0, e.write});
                    chk("issue_le", {31'b0, w_dram_le}, {31'b0, ~e.write});
                    chk("issue_addr", w_dram_addr, e.addr);
                    if (e.write) chk("issue_wdata", w_dram_wdata, e.wdata);
                    chk("issue_ctrl", {29'b0, w_dram_ctrl}, {29'b0, e.ctrl});
                    w_dram_odata = e.rdata;
                    busy_cnt     = busy_len;
                    w_dram_busy  = (busy_len > 0);
                end
            end
        end
    end

    task automatic drive(input int h, input logic le, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        if (h == 0) begin
            w_h0_le = le; w_h0_we = we; w_h0_addr = a; w_h0_wdata = d; w_h0_ctrl = c;
        end else begin
            w_h1_le = le; w_h1_we = we; w_h1_addr = a; w_h1_wdata = d; w_h1_ctrl = c;
        end
    endtask

    task automatic clear_reqs();
        w_h0_le = 1'b0; w_h0_we = 1'b0; w_h1_le = 1'b0; w_h1_we = 1'b0;
    endtask

    // One-cycle request pulse; t0 is the cycle in which the pulse is presented
    task automatic send(input int h, input logic le, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c, output int t0);
        @(posedge CLK); #1;
        drive(h, le, we, a, d, c);
        t0 = cyc;
        @(posedge CLK); #1;
        clear_reqs();
    endtask

    task automatic push_issue(input int h, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] c, input logic [31:0] r);
        issue_t e;
        e.grant = h; e.write = wr; e.addr = a; e.wdata = d; e.ctrl = c; e.rdata = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int h, output int fall_cyc);
        int n = 0;
        while (((h == 0) ? w_h0_busy : w_h1_busy) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        fall_cyc = cyc;
        if (n >= 100) begin
            total_cnt++;
            $display("FAIL timeout_h%0d: got busy stuck high expected busy low within 100 cycles", h);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_h0_busy"}, {31'b0, w_h0_busy}, 32'h0);
        chk({tag, "_h1_busy"}, {31'b0, w_h1_busy}, 32'h0);
        chk({tag, "_h0_odata"}, w_h0_odata, 32'h0);
        chk({tag, "_h1_odata"}, w_h1_odata, 32'h0);
        chk({tag, "_grant"}, w_grant, 32'h0);
        chk({tag, "_dram_addr"}, w_dram_addr, 32'h0);
        chk({tag, "_dram_wdata"}, w_dram_wdata, 32'h0);
        chk({tag, "_dram_ctrl"}, {29'b0, w_dram_ctrl}, 32'h0);
        chk({tag, "_dram_pulses"}, {30'b0, w_dram_le, w_dram_we_t}, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_zero("reset");
        RST = 1'b0;
        exp_odata[0] = '0;
        exp_odata[1] = '0;
    endtask

    vec_t vecs [7];

    initial begin
        int t0, t1, f, pc;

        vecs[0] = '{1, 1'b1, 1'b0, 32'h8000_2000, 32'h0,         3'd2, 32'hCAFE_F00D};
        vecs[1] = '{0, 1'b0, 1'b1, 32'h8000_0040, 32'h0000_0011, 3'd0, 32'h1234_5678};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h8000_0044, 32'h0,         3'd5, 32'hA5A5_5A5A};
        vecs[3] = '{1, 1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 3'd1, 32'h0BAD_0BAD};
        vecs[4] = '{0, 1'b1, 1'b1, 32'h8000_0080, 32'h5555_AAAA, 3'd2, 32'h7777_7777};
        vecs[5] = '{1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         3'd4, 32'h0000_0000};
        vecs[6] = '{0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         3'd7, 32'hFFFF_FFFF};

        repeat (2) @(posedge CLK);
        #1;
        check_zero("por");
        RST = 1'b0;
        exp_odata[0] = '0;
        exp_odata[1] = '0;

        // single load, DRAM busy for 3 cycles
        busy_len = 3;
        push_issue(0, 1'b0, 32'h8000_1000, 32'h0, 3'd2, 32'hDEAD_BEEF);
        send(0, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 3'd2, t0);
        chk("single_busy_high", {31'b0, w_h0_busy}, 32'h1);
        wait_done(0, f);
        chk("single_pulse_cyc", pulse_cyc[0], t0 + 2);
        chk("single_fall_cyc", f, t0 + 6);
        chk("single_odata", w_h0_odata, 32'hDEAD_BEEF);
        chk("single_grant", w_grant, 32'h0);
        exp_odata[0] = 32'hDEAD_BEEF;

        // vector table at minimum latency
        busy_len = 0;
        for (int i = 0; i < 7; i++) begin
            push_issue(vecs[i].hart, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl, vecs[i].rdata);
            send(vecs[i].hart, vecs[i].le, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl, t0);
            wait_done(vecs[i].hart, f);
            if (!vecs[i].we) exp_odata[vecs[i].hart] = vecs[i].rdata;
            chk($sformatf("vec%0d_pulse_cyc", i), pulse_cyc[vecs[i].hart], t0 + 2);
            chk($sformatf("vec%0d_fall_cyc", i), f, t0 + 5);
            chk($sformatf("vec%0d_h0_odata", i), w_h0_odata, exp_odata[0]);
            chk($sformatf("vec%0d_h1_odata", i), w_h1_odata, exp_odata[1]);
            chk($sformatf("vec%0d_grant", i), w_grant, vecs[i].hart);
        end

        // tie right after reset: hart 0 first in both modes
        do_reset();
        busy_len = 2;
        push_issue(0, 1'b1, 32'h8000_0100, 32'h0000_0011, 3'd2, 32'h0);
        push_issue(1, 1'b0, 32'h8000_0200, 32'h0,         3'd2, 32'h7777_0001);
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b1, 32'h8000_0100, 32'h0000_0011, 3'd2);
        drive(1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 3'd2);
        @(posedge CLK); #1;
        clear_reqs();
        wait_done(0, f);
        wait_done(1, f);
        chk("tie1_order", {31'b0, pulse_cyc[0] < pulse_cyc[1]}, 32'h1);
        chk("tie1_h0_odata", w_h0_odata, 32'h0);
        chk("tie1_h1_odata", w_h1_odata, 32'h7777_0001);

        // hart 0 served alone, then a second tie
        push_issue(0, 1'b0, 32'h8000_0300, 32'h0, 3'd2, 32'h3333_0000);
        send(0, 1'b1, 1'b0, 32'h8000_0300, 32'h0, 3'd2, t0);
        wait_done(0, f);
`ifdef DRAM_ARB_RR_EN
        push_issue(1, 1'b0, 32'h8000_0500, 32'h0,         3'd2, 32'h5555_0001);
        push_issue(0, 1'b1, 32'h8000_0400, 32'h0000_0022, 3'd2, 32'h0);
`else
        push_issue(0, 1'b1, 32'h8000_0400, 32'h0000_0022, 3'd2, 32'h0);
        push_issue(1, 1'b0, 32'h8000_0500, 32'h0,         3'd2, 32'h5555_0001);
`endif
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b1, 32'h8000_0400, 32'h0000_0022, 3'd2);
        drive(1, 1'b1, 1'b0, 32'h8000_0500, 32'h0, 3'd2);
        @(posedge CLK); #1;
        clear_reqs();
        wait_done(0, f);
        wait_done(1, f);
`ifdef DRAM_ARB_RR_EN
        chk("tie2_order", {31'b0, pulse_cyc[1] < pulse_cyc[0]}, 32'h1);
`else
        chk("tie2_order", {31'b0, pulse_cyc[0] < pulse_cyc[1]}, 32'h1);
`endif
        chk("tie2_h0_odata", w_h0_odata, 32'h3333_0000);
        chk("tie2_h1_odata", w_h1_odata, 32'h5555_0001);
        exp_odata[0] = 32'h3333_0000;

        // overlap: hart 1 arrives while hart 0 sits in WAIT
        busy_len = 6;
        push_issue(0, 1'b0, 32'h8000_0600, 32'h0, 3'd2, 32'h6666_0000);
        push_issue(1, 1'b0, 32'h8000_0700, 32'h0, 3'd2, 32'h6666_0001);
        send(0, 1'b1, 1'b0, 32'h8000_0600, 32'h0, 3'd2, t0);
        repeat (3) @(posedge CLK);
        send(1, 1'b1, 1'b0, 32'h8000_0700, 32'h0, 3'd2, t1);
        chk("overlap_h1_pend", {31'b0, w_h1_busy}, 32'h1);
        wait_done(0, f);
        chk("overlap_h0_fall", f, t0 + 9);
        chk("overlap_h0_odata", w_h0_odata, 32'h6666_0000);
        wait_done(1, f);
        chk("overlap_h1_issue", pulse_cyc[1], t0 + 10);
        chk("overlap_h0_kept", w_h0_odata, 32'h6666_0000);
        chk("overlap_h1_odata", w_h1_odata, 32'h6666_0001);

        // illegal repeat: second pulse while busy is dropped
        busy_len = 4;
        pc = pulse_cnt;
        push_issue(0, 1'b0, 32'h8000_0800, 32'h0, 3'd2, 32'h8888_0000);
        send(0, 1'b1, 1'b0, 32'h8000_0800, 32'h0, 3'd2, t0);
        drive(0, 1'b1, 1'b0, 32'h8000_0900, 32'h0, 3'd3);
        @(posedge CLK); #1;
        clear_reqs();
        wait_done(0, f);
        repeat (8) @(posedge CLK);
        #1;
        chk("repeat_pulse_count", pulse_cnt - pc, 32'd1);
        chk("repeat_odata", w_h0_odata, 32'h8888_0000);
        chk("repeat_h0_idle", {31'b0, w_h0_busy}, 32'h0);

        // reset while the DRAM is busy
        busy_len = 8;
        push_issue(1, 1'b0, 32'h8000_0A00, 32'h0, 3'd2, 32'hAAAA_0000);
        send(1, 1'b1, 1'b0, 32'h8000_0A00, 32'h0, 3'd2, t0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rstwait_busy_high", {31'b0, w_h1_busy}, 32'h1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_zero("rstwait");
        RST = 1'b0;
        pc = pulse_cnt;
        repeat (12) @(posedge CLK);
        #1;
        chk("rstwait_no_pulse", pulse_cnt - pc, 32'd0);
        chk("rstwait_h1_idle", {31'b0, w_h1_busy}, 32'h0);
        chk("rstwait_h1_odata", w_h1_odata, 32'h0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
